// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: elastic pipeline-stage register. A DEPTH-entry FIFO sits
// between two processor stages with a valid/ready handshake, a branch flush,
// an occupancy count, and a NOP bubble on the output while the stage is empty.
module pipe_stage_buffer #(
  parameter int          WIDTH      = 32,
  parameter int          DEPTH      = 2,
  parameter logic [31:0] BUBBLE_VAL = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  // Keep pointers at least one bit wide so DEPTH=1 still elaborates cleanly.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [WIDTH-1:0] BUBBLE   = WIDTH'(BUBBLE_VAL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Pointers wrap by explicit compare, so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Handshake flags come only from registered occupancy; a full stage never
  // accepts, even in a cycle where the downstream stage is popping.
  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : BUBBLE;
  assign count     = count_q;

  // Next-state for pointers and occupancy; flush wipes everything and
  // swallows any push or pop attempted in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Control state register; reset takes priority over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents of empty slots are never shown, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb_pipe_stage_buffer: two instances (DEPTH=2 and DEPTH=3) driven by directed
// sequences then random traffic. A queue per instance is the reference FIFO:
// accepted payloads are pushed at the clock edge, and a negedge monitor checks
// the handshake/count/bubble outputs and pops-and-compares on every transfer.
module tb_pipe_stage_buffer;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_data   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_data  [2];
  logic        flush     [2];
  logic [1:0]  cnt       [2];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      pipe_stage_buffer #(
        .WIDTH     (32),
        .DEPTH     ((gi == 0) ? 2 : 3),
        .BUBBLE_VAL(32'h0000_0013)
      ) dut (
        .clk      (clk),
        .rst      (rst[gi]),
        .in_valid (in_valid[gi]),
        .in_ready (in_ready[gi]),
        .in_data  (in_data[gi]),
        .out_valid(out_valid[gi]),
        .out_ready(out_ready[gi]),
        .out_data (out_data[gi]),
        .flush    (flush[gi]),
        .count    (cnt[gi])
      );
    end
  endgenerate

  // Reference state
  logic [31:0] exp_q [2][$];
  bit          rdy_snap [2];
  bit          armed    [2];
  int          n_err    = 0;
  int          n_checks = 0;

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  // Reference model update at the edge: reset/flush empty the queue, and an
  // offer made while the stage was not full is accepted in FIFO order.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        exp_q[k].delete();
        armed[k] = 1'b1;
      end else if (flush[k]) begin
        exp_q[k].delete();
      end else if (in_valid[k] && rdy_snap[k]) begin
        exp_q[k].push_back(in_data[k]);
      end
    end
  end

  // Monitor: check visible state mid-cycle, then retire the head when the
  // DUT presents a transfer that the coming edge will complete.
  always @(negedge clk) begin
    int sz;
    for (int k = 0; k < 2; k++) begin
      sz = exp_q[k].size();
      rdy_snap[k] = (sz != dep(k));
      if (armed[k]) begin
        chk("count",     k, {30'd0, cnt[k]}, sz);
        chk("in_ready",  k, {31'd0, in_ready[k]}, {31'd0, sz != dep(k)});
        chk("out_valid", k, {31'd0, out_valid[k]}, {31'd0, sz != 0});
        if (sz == 0) begin
          chk("bubble", k, out_data[k], 32'h0000_0013);
        end
        if (out_valid[k] && out_ready[k] && !flush[k] && !rst[k]) begin
          if (sz == 0) begin
            chk("pop_on_empty", k, 32'd1, 32'd0);
          end else begin
            chk("pop_data", k, out_data[k], exp_q[k][0]);
            $display("inst%0d pop data=%h count=%0d", k, out_data[k], cnt[k]);
            void'(exp_q[k].pop_front());
          end
        end
      end
    end
  end

  task automatic set_in(input int k, input bit v, input logic [31:0] d,
                        input bit ordy, input bit fl, input bit r);
    in_valid[k]  = v;
    in_data[k]   = d;
    out_ready[k] = ordy;
    flush[k]     = fl;
    rst[k]       = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rdy_snap[k] = 1'b1;
      armed[k]    = 1'b0;
      set_in(k, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    end
    tick();
    tick();
    set_in(0, 0, 32'd0, 0, 0, 0);
    set_in(1, 0, 32'd0, 0, 0, 0);
    tick();
    tick();

    // DEPTH=2: fill, offer a third entry while full
    set_in(0, 1, 32'hA1, 0, 0, 0); tick();
    set_in(0, 1, 32'hB2, 0, 0, 0); tick();
    set_in(0, 1, 32'hC3, 0, 0, 0); tick();
    tick();
    // Pop from full while offering C3: first edge pops only, second pushes+pops
    set_in(0, 1, 32'hC3, 1, 0, 0); tick();
    tick();
    set_in(0, 0, 32'd0, 1, 0, 0);  tick();
    // Flush dominates push and pop
    set_in(0, 1, 32'h55, 0, 0, 0); tick();
    set_in(0, 1, 32'h66, 1, 1, 0); tick();
    set_in(0, 0, 32'd0, 1, 0, 0);  tick();
    tick();

    // DEPTH=3: wrap-around ordering
    set_in(1, 1, 32'd1, 0, 0, 0); tick();
    set_in(1, 1, 32'd2, 0, 0, 0); tick();
    set_in(1, 1, 32'd3, 0, 0, 0); tick();
    set_in(1, 0, 32'd0, 1, 0, 0); tick();
    tick();
    set_in(1, 1, 32'd4, 0, 0, 0); tick();
    set_in(1, 1, 32'd5, 0, 0, 0); tick();
    set_in(1, 0, 32'd0, 1, 0, 0); tick();
    tick();
    tick();
    tick();
    // Reset mid-stream with a push pending, then a fresh push
    set_in(1, 1, 32'd7, 0, 0, 0);     tick();
    set_in(1, 1, 32'd8, 0, 0, 0);     tick();
    set_in(1, 1, 32'd9, 0, 0, 1);     tick();
    set_in(1, 1, 32'hAB, 0, 0, 0);    tick();
    set_in(1, 0, 32'd0, 1, 0, 0);     tick();
    tick();

    // Random traffic on both instances
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        set_in(k, $urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1) == 1,
               $urandom_range(0, 29) == 0, $urandom_range(0, 79) == 0);
      end
      tick();
    end
    // Drain
    for (int k = 0; k < 2; k++) set_in(k, 0, 32'd0, 1, 0, 0);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised elastic pipeline-stage register that replaces the per-signal stage latches (decode/execute/memory/writeback) with one bundled FIFO stage.
- Adds a valid/ready handshake, DEPTH-entry buffering, a branch flush, an occupancy count and bubble injection (NOP presented when empty).
- Sits between any two processor pipeline stages; the upstream stage drives in_*, the downstream stage consumes out_*.

Parameters:
- WIDTH, 32, bit width of the bundled stage payload (instruction, PC, control fields concatenated by the instantiator).
- DEPTH, 2, number of buffer entries; legal range >= 1, need not be a power of two.
- BUBBLE_VAL, 32'h0000_0013, value driven on out_data when the stage is empty. The default is the RV32I NOP (addi x0,x0,0), zero-extended/truncated to WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream presents in_data
- in_ready  out  1  stage can accept an entry this cycle
- in_data  in  WIDTH  payload from upstream
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream consumes the head this cycle
- out_data  out  WIDTH  head payload, or BUBBLE_VAL when empty
- flush  in  1  discard all entries (branch taken / clrBU)
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- One clock domain. Reset is synchronous, active-high: on a clk edge with rst=1, entries are invalidated, count=0, and read/write pointers=0.
- Outputs after reset: out_valid=0, out_data=BUBBLE_VAL, in_ready=1, count=0.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It is a registered-state function with no combinational path from out_ready, so a full buffer never accepts, even when popping that same cycle.
- out_valid = (count != 0). out_data = storage[rd_ptr] when out_valid, else BUBBLE_VAL.
- Latency: an entry pushed at edge N is visible at the output after edge N (out_valid=1 in cycle N+1). There is no same-cycle pass-through.
- Ordering is strict FIFO.
- Pointers increment modulo DEPTH, wrapping from DEPTH-1 to 0 with explicit compare, not bit truncation.
- count updates:
  - push only: +1
  - pop only: -1
  - push & pop: unchanged, both pointers advance
  - neither: unchanged
- flush=1 at an edge: count=0, pointers=0, all entries invalid. Any push or pop in that cycle is discarded; flush dominates both.
- rst dominates flush.
- in_data is sampled only when push is true. Storage contents are don't-care while invalid, but out_data must still show BUBBLE_VAL.
- Payload held steady: while out_valid=1 and out_ready=0, out_data and out_valid hold indefinitely (stall).
- count never exceeds DEPTH and never underflows; pop on empty or push on full are no-ops by construction.
- DEPTH=1 degenerates to a plain stage register with valid bit and flush.

Test Plan:
- Reset, then idle, WIDTH=32, DEPTH=2 -> out_valid=0, out_data=32'h00000013, in_ready=1, count=0.
- Push 32'hA1 then 32'hB2 with out_ready=0 -> after 2 edges count=2, in_ready=0, out_data=32'hA1. A third push of 32'hC3 is ignored; count stays 2.
- From full (A1,B2), hold in_valid=1 with 32'hC3 and out_ready=1 -> edge 1 pops A1 (no push), edge 2 pushes C3 and pops B2, count=1, out_data=32'hC3.
- With count=1 holding 32'h55, assert flush, in_valid=1 (32'h66) and out_ready=1 in one cycle -> next cycle count=0, out_valid=0, out_data=32'h13; 32'h66 is never output.
- DEPTH=3: push 1,2,3; pop 1,2; push 4,5; pop all -> output order 1,2,3,4,5 with correct wrap, and count sequence 3,2,1,2,3,2,1,0.
- Assert rst mid-stream with count=2 and push active -> next cycle count=0, out_valid=0, in_ready=1; the first post-reset push appears one cycle later with correct data.
